// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from NUM_REQ requesters into one shared UART transmitter.
// A multi-byte packet keeps the grant locked on its owner until the byte marked last is accepted.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          grant_active
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StStart, StWaitBusy, StWaitDone} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [IdW-1:0]        grant_id_q, grant_id_d;
    logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                  lock_q, lock_d;
    logic                  quiet_q, quiet_d;

    logic                  win_found;
    logic [IdW-1:0]        win_idx;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  accept;
    logic                  complete;
    int unsigned           cand;
    logic [IdW-1:0]        cand_id;

    always_comb begin
        win_found = 1'b0;
        win_idx   = grant_id_q;
        cand      = '0;
        cand_id   = '0;
        if (lock_q) begin
            win_found = req_valid[grant_id_q];
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = 32'(rr_ptr_q) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                cand_id = IdW'(cand);
                if (!win_found && req_valid[cand_id]) begin
                    win_found = 1'b1;
                    win_idx   = cand_id;
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IdW'(i)) begin
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // rst_n gates the strobe so no requester sees an accept while reset is held.
    assign accept = (state_q == StIdle) && !tx_busy && win_found && rst_n;

    always_comb begin
        req_ready          = '0;
        req_ready[win_idx] = accept;
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        lock_d     = lock_q;
        rr_ptr_d   = rr_ptr_q;
        quiet_d    = quiet_q;
        complete   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    tx_data_d  = win_data;
                    grant_id_d = win_idx;
                    lock_d     = !req_last[win_idx];
                    state_d    = StStart;
                end
            end
            StStart: begin
                quiet_d = 1'b0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                // A transmitter that never raises busy is treated as done after two quiet cycles.
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (quiet_q) begin
                    complete = 1'b1;
                end else begin
                    quiet_d = 1'b1;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    complete = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (complete) begin
            state_d = StIdle;
            if (!lock_q) begin
                rr_ptr_d = (grant_id_q == IdW'(NUM_REQ - 1)) ? '0 : grant_id_q + IdW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            quiet_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            quiet_q    <= quiet_d;
        end
    end

    assign tx_start     = (state_q == StStart);
    assign tx_data      = tx_data_q;
    assign grant_id     = grant_id_q;
    assign grant_active = lock_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte sources, a transmitter stand-in and a
// transaction-level reference model compared against the outputs every cycle.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int QD = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_start;
    logic [DW-1:0]   tx_data;
    logic            tx_busy;
    logic [1:0]      grant_id;
    logic            grant_active;

    logic            xmit_busy;
    logic            ext_busy;
    int              busy_len;

    assign tx_busy = xmit_busy | ext_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .grant_active(grant_active)
    );

    int total;
    int bad;

    // Per-requester byte sources: {last, data}.
    logic [8:0] src_mem [N][QD];
    int         src_rd  [N];
    int         src_wr  [N];

    int acc_id  [$];
    int acc_dat [$];
    int acc_cyc [$];
    int start_cnt;

    // Reference model state: one in-flight byte at a time.
    bit       m_pend;
    bit       m_fly;
    bit       m_seen;
    bit       m_lock;
    int       m_quiet;
    int       m_owner;
    int       m_ptr;
    logic [7:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr, input bit lock,
                                input int owner);
        if (lock) return v[owner] ? owner : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src_mem[r][src_wr[r]] = {l, d};
        src_wr[r]++;
    endtask

    task automatic drive_inputs();
        for (int r = 0; r < N; r++) begin
            if (src_rd[r] < src_wr[r]) begin
                req_valid[r]          = 1'b1;
                req_last[r]           = src_mem[r][src_rd[r]][8];
                req_data[r*DW +: DW]  = src_mem[r][src_rd[r]][7:0];
            end else begin
                req_valid[r]          = 1'b0;
                req_last[r]           = 1'b0;
                req_data[r*DW +: DW]  = '0;
            end
        end
    endtask

    task automatic driver();
        logic [N-1:0] rdy;
        int dcyc = 0;
        forever begin
            @(negedge clk);
            rdy = req_ready;
            dcyc++;
            @(posedge clk);
            #1;
            for (int r = 0; r < N; r++) begin
                if (rdy[r] && src_rd[r] < src_wr[r]) begin
                    acc_id.push_back(r);
                    acc_dat.push_back(int'(src_mem[r][src_rd[r]][7:0]));
                    acc_cyc.push_back(dcyc);
                    src_rd[r]++;
                end
            end
            drive_inputs();
        end
    endtask

    // Transmitter stand-in: busy for busy_len cycles after each start pulse.
    task automatic xmit();
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && busy_len > 0) begin
                @(posedge clk);
                #1;
                xmit_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1;
                xmit_busy = 1'b0;
            end
        end
    endtask

    task automatic model_run();
        int  w;
        bit  done;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pend = 0; m_fly = 0; m_seen = 0; m_lock = 0;
                m_quiet = 0; m_owner = 0; m_ptr = 0; m_data = '0;
            end else if (m_fly) begin
                done = 0;
                if (m_seen) begin
                    if (!tx_busy) done = 1;
                end else if (tx_busy) begin
                    m_seen = 1;
                end else begin
                    m_quiet++;
                    if (m_quiet == 2) done = 1;
                end
                if (done) begin
                    m_fly = 0; m_seen = 0; m_quiet = 0;
                    if (!m_lock) m_ptr = (m_owner + 1) % N;
                end
            end else if (m_pend) begin
                m_pend  = 0;
                m_fly   = 1;
                m_quiet = 0;
            end else if (!tx_busy) begin
                w = pick(req_valid, m_ptr, m_lock, m_owner);
                if (w >= 0) begin
                    m_data  = req_data[w*DW +: DW];
                    m_owner = w;
                    m_lock  = !req_last[w];
                    m_pend  = 1;
                end
            end
        end
    endtask

    task automatic compare_loop();
        logic [N-1:0] er;
        int w;
        forever begin
            @(negedge clk);
            er = '0;
            w  = pick(req_valid, m_ptr, m_lock, m_owner);
            if (rst_n && !m_pend && !m_fly && !tx_busy && w >= 0) er[w] = 1'b1;
            if (tx_start === 1'b1) start_cnt++;
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("tx_start", 32'(tx_start), 32'(m_pend));
            chk("tx_data", 32'(tx_data), 32'(m_data));
            chk("grant_id", 32'(grant_id), m_owner);
            chk("grant_active", 32'(grant_active), 32'(m_lock));
        end
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n = 0;
        while (acc_id.size() < target && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("accept_count", acc_id.size(), target);
    endtask

    task automatic check_acc(input int k, input int id, input int d);
        if (k < acc_id.size()) begin
            chk("acc_id", acc_id[k], id);
            chk("acc_data", acc_dat[k], d);
        end else begin
            chk("acc_missing", acc_id.size(), k + 1);
        end
    endtask

    task automatic check_gap(input int k, input int gap);
        if (k + 1 < acc_cyc.size()) chk("acc_gap", acc_cyc[k+1] - acc_cyc[k], gap);
        else chk("gap_missing", acc_cyc.size(), k + 2);
    endtask

    initial begin
        int base;
        total = 0; bad = 0; start_cnt = 0;
        rst_n = 1'b0; xmit_busy = 1'b0; ext_busy = 1'b0; busy_len = 2;
        req_valid = '0; req_data = '0; req_last = '0;
        m_pend = 0; m_fly = 0; m_seen = 0; m_lock = 0;
        m_quiet = 0; m_owner = 0; m_ptr = 0; m_data = '0;
        for (int r = 0; r < N; r++) begin
            src_rd[r] = 0;
            src_wr[r] = 0;
        end
        // All four requesters hold two single-byte packets from reset onward.
        for (int j = 0; j < 2; j++) begin
            for (int r = 0; r < N; r++) push(r, 8'(r * 16 + j), 1'b1);
        end
        fork
            driver();
            xmit();
            model_run();
            compare_loop();
        join_none

        // Reset with requests pending: nothing may be offered or granted.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid_seen", 32'(req_valid), 32'hf);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_grant_active", 32'(grant_active), 0);
        chk("rst_no_accept", acc_id.size(), 0);
        rst_n = 1'b1;

        // Round robin from reset: 0,1,2,3,0,1,2,3.
        wait_acc(8, 120);
        for (int k = 0; k < 8; k++) check_acc(k, k % 4, (k % 4) * 16 + k / 4);
        check_gap(0, 5);
        check_gap(4, 5);
        repeat (10) @(posedge clk);
        #2;
        chk("rr_start_count", start_cnt, 8);

        // Single request with a 10-cycle busy pulse.
        busy_len = 10;
        base = acc_id.size();
        push(2, 8'h55, 1'b1);
        wait_acc(base + 1, 30);
        check_acc(base, 2, 8'h55);
        repeat (16) @(posedge clk);
        #2;
        chk("single_tx_data", 32'(tx_data), 32'h55);
        chk("single_grant_id", 32'(grant_id), 2);
        chk("single_grant_active", 32'(grant_active), 0);
        // Pointer now sits at 3, so 3 beats 0.
        push(0, 8'h01, 1'b1);
        push(3, 8'h03, 1'b1);
        wait_acc(base + 3, 60);
        check_acc(base + 1, 3, 8'h03);
        check_acc(base + 2, 0, 8'h01);
        check_gap(base + 1, 13);
        repeat (16) @(posedge clk);

        // Transmitter never busy: completion after two quiet cycles.
        busy_len = 0;
        base = acc_id.size();
        push(0, 8'h11, 1'b1);
        push(1, 8'h12, 1'b1);
        wait_acc(base + 2, 30);
        check_acc(base, 1, 8'h12);
        check_acc(base + 1, 0, 8'h11);
        check_gap(base, 4);
        repeat (8) @(posedge clk);

        // Packet lock on requester 1 while requester 0 waits.
        busy_len = 3;
        base = acc_id.size();
        push(1, 8'hA0, 1'b0);
        push(1, 8'hA1, 1'b0);
        push(1, 8'hA2, 1'b1);
        push(0, 8'h10, 1'b1);
        wait_acc(base + 1, 30);
        chk("lock_active", 32'(grant_active), 1);
        chk("lock_owner", 32'(grant_id), 1);
        wait_acc(base + 4, 60);
        check_acc(base, 1, 8'hA0);
        check_acc(base + 1, 1, 8'hA1);
        check_acc(base + 2, 1, 8'hA2);
        check_acc(base + 3, 0, 8'h10);
        check_gap(base, 6);
        check_gap(base + 1, 6);
        check_gap(base + 2, 6);
        repeat (10) @(posedge clk);
        #2;
        chk("lock_released", 32'(grant_active), 0);

        // Locked requester 3 stalls mid-packet; others must wait.
        base = acc_id.size();
        push(3, 8'h30, 1'b0);
        push(3, 8'h31, 1'b0);
        wait_acc(base + 2, 40);
        push(0, 8'h40, 1'b1);
        push(1, 8'h41, 1'b1);
        repeat (25) @(posedge clk);
        #2;
        chk("stall_no_accept", acc_id.size(), base + 2);
        chk("stall_ready", 32'(req_ready), 0);
        chk("stall_active", 32'(grant_active), 1);
        chk("stall_owner", 32'(grant_id), 3);
        push(3, 8'h32, 1'b1);
        wait_acc(base + 5, 60);
        check_acc(base + 2, 3, 8'h32);
        check_acc(base + 3, 0, 8'h40);
        check_acc(base + 4, 1, 8'h41);
        repeat (10) @(posedge clk);

        // External busy in idle blocks acceptance.
        base = acc_id.size();
        ext_busy = 1'b1;
        push(2, 8'h66, 1'b1);
        repeat (6) @(posedge clk);
        #2;
        chk("ext_busy_no_accept", acc_id.size(), base);
        chk("ext_busy_ready", 32'(req_ready), 0);
        ext_busy = 1'b0;
        wait_acc(base + 1, 20);
        check_acc(base, 2, 8'h66);
        repeat (10) @(posedge clk);

        // Reset asserted in WAIT_DONE with a lock held by requester 2.
        busy_len = 10;
        base = acc_id.size();
        push(2, 8'h72, 1'b0);
        wait_acc(base + 1, 20);
        push(1, 8'h71, 1'b1);
        push(3, 8'h73, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        chk("pre_rst_active", 32'(grant_active), 1);
        chk("pre_rst_data", 32'(tx_data), 32'h72);
        chk("pre_rst_owner", 32'(grant_id), 2);
        rst_n = 1'b0;
        #1;
        chk("async_tx_start", 32'(tx_start), 0);
        chk("async_req_ready", 32'(req_ready), 0);
        chk("async_tx_data", 32'(tx_data), 0);
        chk("async_grant_id", 32'(grant_id), 0);
        chk("async_grant_active", 32'(grant_active), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_no_accept", acc_id.size(), base + 1);
        rst_n = 1'b1;
        wait_acc(base + 3, 60);
        check_acc(base + 1, 1, 8'h71);
        check_acc(base + 2, 3, 8'h73);
        repeat (20) @(posedge clk);
        #2;
        chk("start_count_vs_accepts", start_cnt, acc_id.size());
        chk("start_count_total", start_cnt, 26);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
